// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit core: ALU op codes, register widths and the EX slot layout.
package cpu_pkg;

   localparam int DW  = 16;
   localparam int RAW = 4;
   localparam logic [RAW-1:0] REG_NONE = 4'hF;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_SLL = 4'd4,
      ALU_SRL = 4'd5,
      ALU_SRA = 4'd6
   } alu_op_e;

   typedef struct packed {
      logic           valid;
      logic [3:0]     alu_op;
      logic [DW-1:0]  src_a;
      logic [DW-1:0]  src_b;
      logic [DW-1:0]  store;
      logic [RAW-1:0] rd;
      logic           reg_write;
      logic           mem_read;
      logic           mem_write;
   } ex_slot_t;

   localparam ex_slot_t EX_BUBBLE = '{
      valid: 1'b0, alu_op: ALU_ADD, src_a: '0, src_b: '0, store: '0,
      rd: REG_NONE, reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0
   };

   // True when the instruction in ID reads dst; rt only counts when it is actually consumed.
   function automatic logic reads_dst(input logic [RAW-1:0] rs,
                                      input logic [RAW-1:0] rt,
                                      input logic           rt_used,
                                      input logic [RAW-1:0] dst);
      return (dst != REG_NONE) && ((rs == dst) || (rt_used && (rt == dst)));
   endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// One operand bypass: picks the youngest enabled stage tap matching the source address, else regfile data.
module fwd_mux
   import cpu_pkg::*;
(
   input  logic [RAW-1:0] src_addr_i,
   input  logic [DW-1:0]  rf_data_i,
   input  logic           ex_en_i,
   input  logic [RAW-1:0] ex_rd_i,
   input  logic [DW-1:0]  ex_data_i,
   input  logic           mem_en_i,
   input  logic [RAW-1:0] mem_rd_i,
   input  logic [DW-1:0]  mem_data_i,
   input  logic           wb_en_i,
   input  logic [RAW-1:0] wb_rd_i,
   input  logic [DW-1:0]  wb_data_i,
   output logic [DW-1:0]  data_o
);

   always_comb begin
      data_o = rf_data_i;
      if (src_addr_i != REG_NONE) begin
         if (ex_en_i && (ex_rd_i == src_addr_i)) begin
            data_o = ex_data_i;
         end else if (mem_en_i && (mem_rd_i == src_addr_i)) begin
            data_o = mem_data_i;
         end else if (wb_en_i && (wb_rd_i == src_addr_i)) begin
            data_o = wb_data_i;
         end
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU; 1-cycle latency, RAW hazards resolved by bypass or bubble stall.
// FORWARDING_EN selects bypass (stall on load-use only); undefined, any pending write to a source stalls.
module id_ex_stage
   import cpu_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           hold,
   input  logic           flush,
   input  logic           id_valid,
   input  logic [3:0]     id_alu_op,
   input  logic [RAW-1:0] id_rs_addr,
   input  logic [RAW-1:0] id_rt_addr,
   input  logic [RAW-1:0] id_rd_addr,
   input  logic [DW-1:0]  id_rs_data,
   input  logic [DW-1:0]  id_rt_data,
   input  logic [DW-1:0]  id_imm,
   input  logic           id_use_imm,
   input  logic           id_reg_write,
   input  logic           id_mem_read,
   input  logic           id_mem_write,
   input  logic [DW-1:0]  ex_result,
   input  logic [RAW-1:0] mem_rd_addr,
   input  logic           mem_reg_write,
   input  logic [DW-1:0]  mem_result,
   input  logic [RAW-1:0] wb_rd_addr,
   input  logic           wb_reg_write,
   input  logic [DW-1:0]  wb_result,
   output logic           hazard_stall,
   output logic           ex_valid,
   output logic [3:0]     ex_alu_op,
   output logic [DW-1:0]  ex_src_a,
   output logic [DW-1:0]  ex_src_b,
   output logic [DW-1:0]  ex_store_data,
   output logic [RAW-1:0] ex_rd_addr,
   output logic           ex_reg_write,
   output logic           ex_mem_read,
   output logic           ex_mem_write
);

   ex_slot_t      ex_q, ex_d;
   logic [DW-1:0] rs_fwd, rt_fwd;
   logic          ex_fwd_en, mem_fwd_en, wb_fwd_en;
   logic          rt_used;

   assign rt_used = !id_use_imm || id_mem_write;

`ifdef FORWARDING_EN
   // A load's data only exists after MEM, so the EX tap is for ALU results only.
   assign ex_fwd_en  = ex_q.valid && ex_q.reg_write && !ex_q.mem_read;
   assign mem_fwd_en = mem_reg_write;
   assign wb_fwd_en  = wb_reg_write;

   assign hazard_stall = ex_q.valid && ex_q.mem_read &&
                         reads_dst(id_rs_addr, id_rt_addr, rt_used, ex_q.rd);
`else
   assign ex_fwd_en  = 1'b0;
   assign mem_fwd_en = 1'b0;
   assign wb_fwd_en  = 1'b0;

   assign hazard_stall =
      (ex_q.valid && ex_q.reg_write && reads_dst(id_rs_addr, id_rt_addr, rt_used, ex_q.rd)) ||
      (mem_reg_write && reads_dst(id_rs_addr, id_rt_addr, rt_used, mem_rd_addr)) ||
      (wb_reg_write  && reads_dst(id_rs_addr, id_rt_addr, rt_used, wb_rd_addr));
`endif

   fwd_mux u_fwd_rs (
      .src_addr_i (id_rs_addr),
      .rf_data_i  (id_rs_data),
      .ex_en_i    (ex_fwd_en),
      .ex_rd_i    (ex_q.rd),
      .ex_data_i  (ex_result),
      .mem_en_i   (mem_fwd_en),
      .mem_rd_i   (mem_rd_addr),
      .mem_data_i (mem_result),
      .wb_en_i    (wb_fwd_en),
      .wb_rd_i    (wb_rd_addr),
      .wb_data_i  (wb_result),
      .data_o     (rs_fwd)
   );

   fwd_mux u_fwd_rt (
      .src_addr_i (id_rt_addr),
      .rf_data_i  (id_rt_data),
      .ex_en_i    (ex_fwd_en),
      .ex_rd_i    (ex_q.rd),
      .ex_data_i  (ex_result),
      .mem_en_i   (mem_fwd_en),
      .mem_rd_i   (mem_rd_addr),
      .mem_data_i (mem_result),
      .wb_en_i    (wb_fwd_en),
      .wb_rd_i    (wb_rd_addr),
      .wb_data_i  (wb_result),
      .data_o     (rt_fwd)
   );

   // hold freezes everything, including a concurrent flush.
   always_comb begin
      ex_d = ex_q;
      if (!hold) begin
         if (flush || hazard_stall || !id_valid) begin
            ex_d = EX_BUBBLE;
         end else begin
            ex_d.valid     = 1'b1;
            ex_d.alu_op    = id_alu_op;
            ex_d.src_a     = rs_fwd;
            ex_d.src_b     = id_use_imm ? id_imm : rt_fwd;
            ex_d.store     = rt_fwd;
            ex_d.rd        = id_rd_addr;
            ex_d.reg_write = id_reg_write;
            ex_d.mem_read  = id_mem_read;
            ex_d.mem_write = id_mem_write;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_q <= EX_BUBBLE;
      end else begin
         ex_q <= ex_d;
      end
   end

   assign ex_valid      = ex_q.valid;
   assign ex_alu_op     = ex_q.alu_op;
   assign ex_src_a      = ex_q.src_a;
   assign ex_src_b      = ex_q.src_b;
   assign ex_store_data = ex_q.store;
   assign ex_rd_addr    = ex_q.rd;
   assign ex_reg_write  = ex_q.reg_write;
   assign ex_mem_read   = ex_q.mem_read;
   assign ex_mem_write  = ex_q.mem_write;

endmodule
